// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the instruction-fetch front end.
//   NOP_INSTR     : bubble instruction placed in IF/ID (MOV r0,r0)
//   fetch_state_t : fetch controller states
//   ifid_t        : contents of the IF/ID pipeline register
// -----------------------------------------------------------------------------
package arm_pkg;

    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

    // BOOT : single bubble cycle after reset, no memory request
    // RUN  : request issued, previous fetch (if any) completed
    // WAIT : request outstanding, memory has not answered yet
    typedef enum logic [1:0] {
        BOOT,
        RUN,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus8;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/pipe_fetch_deco.sv
// -----------------------------------------------------------------------------
// pipe_fetch_deco
// IF/ID pipeline register with flush, stall and bubble insertion.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   flush_i          : load a bubble (flush or PC redirect), highest priority
//   stall_i          : hold the current contents
//   load_i           : capture a completed fetch
//   instr_i          : fetched instruction word
//   pc_plus8_i       : PC of the instruction in IF plus 8
//   instr_o          : instruction presented to decode
//   pc_plus8_o       : r15 read value for that instruction
//   valid_o          : instr_o is a real fetched instruction
// -----------------------------------------------------------------------------
module pipe_fetch_deco
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus8_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus8_o,
    output logic        valid_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        // NOTE: default to the held value first so no path through this block infers a latch.
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d.instr    = NOP_INSTR;
            ifid_d.pc_plus8 = pc_plus8_i;
            ifid_d.valid    = 1'b0;
        end else if (stall_i) begin
            ifid_d = ifid_q;
        end else if (load_i) begin
            ifid_d.instr    = instr_i;
            ifid_d.pc_plus8 = pc_plus8_i;
            ifid_d.valid    = 1'b1;
        end else begin
            // Nothing usable this cycle: bubble, but keep r15 tracking the PC.
            ifid_d.instr    = NOP_INSTR;
            ifid_d.pc_plus8 = pc_plus8_i;
            ifid_d.valid    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus8: RESET_PC + 32'd8, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign instr_o    = ifid_q.instr;
    assign pc_plus8_o = ifid_q.pc_plus8;
    assign valid_o    = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: PC register, next-PC selection, instruction-memory
// handshake FSM, saturating fetch statistics and the IF/ID register.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   StallF / StallD / FlushD    : hazard-unit controls for PC and IF/ID
//   BranchTakenE, BranchTargetE : branch redirect from execute
//   PCSrcW, ResultW             : r15 write redirect from writeback
//   imem_addr, imem_req         : fetch address (= PCF) and request
//   imem_rdata, imem_valid      : instruction word and its valid strobe
//   InstrD, PCPlus8D, ValidD    : IF/ID outputs to decode
//   FetchCnt, MissCnt           : instructions delivered / memory-miss cycles
// -----------------------------------------------------------------------------
module fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [31:0]      BranchTargetE,
    input  logic             PCSrcW,
    input  logic [31:0]      ResultW,
    output logic [31:0]      imem_addr,
    output logic             imem_req,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_valid,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCPlus8D,
    output logic             ValidD,
    output logic [CNT_W-1:0] FetchCnt,
    output logic [CNT_W-1:0] MissCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic        redirect;
    logic        fetch_req;
    logic        fetch_ok;
    logic        miss;
    logic        deliver;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [31:0] next_pc;

    // ------------------------------------------------------------------
    // Fetch handshake qualifiers
    // ------------------------------------------------------------------
    assign fetch_req = (state_q != BOOT);
    assign fetch_ok  = fetch_req & imem_valid;
    // Every requesting cycle without data is a cycle lost to memory,
    // including the RUN cycle in which the miss is first seen.
    assign miss      = fetch_req & ~imem_valid;
    assign redirect  = BranchTakenE | PCSrcW;

    // An instruction only reaches decode if IF/ID actually captures it.
    assign deliver   = fetch_ok & ~StallF & ~StallD & ~FlushD & ~redirect;

    // ------------------------------------------------------------------
    // Next-PC selection (32-bit wrap-around is intended)
    // ------------------------------------------------------------------
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;
    assign next_pc  = BranchTakenE ? BranchTargetE :
                      PCSrcW       ? ResultW       : pc_plus4;

    // ------------------------------------------------------------------
    // FSM, PC and counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_cnt_d = fetch_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = imem_valid ? RUN : WAIT;
            WAIT:    state_d = imem_valid ? RUN : WAIT;
            default: state_d = BOOT;
        endcase

        // A redirect abandons any outstanding fetch and re-requests at once.
        if (redirect) begin
            state_d = RUN;
            pc_d    = next_pc;
        end else if (StallF) begin
            // A fetch completing under StallF is dropped; same PC refetched.
            pc_d    = pc_q;
        end else if (fetch_ok) begin
            pc_d    = pc_plus4;
        end

        if (deliver && (fetch_cnt_q != CNT_MAX)) begin
            fetch_cnt_d = fetch_cnt_q + CNT_ONE;
        end
        if (miss && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    pipe_fetch_deco #(
        .RESET_PC (RESET_PC)
    ) u_deco (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (FlushD | redirect),
        .stall_i    (StallD),
        .load_i     (fetch_ok & ~StallF),
        .instr_i    (imem_rdata),
        .pc_plus8_i (pc_plus8),
        .instr_o    (InstrD),
        .pc_plus8_o (PCPlus8D),
        .valid_o    (ValidD)
    );

    assign imem_addr = pc_q;
    assign imem_req  = fetch_req;
    assign FetchCnt  = fetch_cnt_q;
    assign MissCnt   = miss_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed plus randomized bench for fetch_stage. A cycle-level behavioural
// model of the fetch rules (PC, IF/ID contents, counters) predicts every output.
// A second instance with RESET_PC=0x8000 exercises a non-zero reset vector.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          CNT_W   = 5;
    localparam int          CNT_MAX = 31;
    localparam logic [31:0] NOP     = 32'hE1A0_0000;
    localparam logic [31:0] RST2    = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] BranchTargetE, ResultW;
    logic        imem_valid;

    logic [31:0]      imem_addr, imem_rdata, InstrD, PCPlus8D;
    logic             imem_req, ValidD;
    logic [CNT_W-1:0] FetchCnt, MissCnt;

    logic [31:0] imem_addr2, imem_rdata2, InstrD2, PCPlus8D2;
    logic        imem_req2, ValidD2;
    logic [15:0] FetchCnt2, MissCnt2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_p8;
    bit          m_boot, m_valid, m_p8_ok;
    int          m_fcnt, m_mcnt;

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata2 = mem_word(imem_addr2);

    fetch_stage #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
        .FetchCnt(FetchCnt), .MissCnt(MissCnt)
    );

    fetch_stage #(.RESET_PC(RST2), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .imem_addr(imem_addr2), .imem_req(imem_req2),
        .imem_rdata(imem_rdata2), .imem_valid(imem_valid),
        .InstrD(InstrD2), .PCPlus8D(PCPlus8D2), .ValidD(ValidD2),
        .FetchCnt(FetchCnt2), .MissCnt(MissCnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input logic [31:0] rpc);
        m_pc    = rpc;
        m_boot  = 1;
        m_instr = NOP;
        m_p8    = rpc + 32'd8;
        m_p8_ok = 1;
        m_valid = 0;
        m_fcnt  = 0;
        m_mcnt  = 0;
    endtask

    task automatic idle();
        StallF = 0; StallD = 0; FlushD = 0;
        BranchTakenE = 0; BranchTargetE = 32'h0;
        PCSrcW = 0; ResultW = 32'h0;
        imem_valid = 1;
    endtask

    task automatic check_reset_values();
        check("rst_instr",    InstrD,            NOP);
        check("rst_pcplus8",  PCPlus8D,          32'h8);
        check("rst_valid",    {31'b0, ValidD},   32'h0);
        check("rst_fetchcnt", {27'b0, FetchCnt}, 32'h0);
        check("rst_misscnt",  {27'b0, MissCnt},  32'h0);
        check("rst_addr",     imem_addr,         32'h0);
        check("rst_req",      {31'b0, imem_req}, 32'h0);
        check("rst2_addr",    imem_addr2,        RST2);
        check("rst2_pcplus8", PCPlus8D2,         RST2 + 32'd8);
        check("rst2_valid",   {31'b0, ValidD2},  32'h0);
    endtask

    // One clock cycle: inputs are already applied. Checks the combinational
    // request, advances the model by the fetch rules, then checks registers.
    task automatic step();
        bit          redirect, fetch_ok, miss;
        logic [31:0] npc;
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("imem_req", {31'b0, imem_req}, {31'b0, !m_boot});

        redirect = BranchTakenE || PCSrcW;
        npc      = BranchTakenE ? BranchTargetE : (PCSrcW ? ResultW : m_pc + 32'd4);
        fetch_ok = !m_boot && imem_valid;
        miss     = !m_boot && !imem_valid;

        if (FlushD || redirect) begin
            m_instr = NOP; m_valid = 0; m_p8_ok = 0;
        end else if (StallD) begin
            // IF/ID unchanged
        end else if (fetch_ok && !StallF) begin
            m_instr = mem_word(m_pc); m_p8 = m_pc + 32'd8; m_p8_ok = 1; m_valid = 1;
            if (m_fcnt < CNT_MAX) m_fcnt++;
        end else begin
            m_instr = NOP; m_valid = 0; m_p8 = m_pc + 32'd8; m_p8_ok = 1;
        end
        if (miss && m_mcnt < CNT_MAX) m_mcnt++;
        if (redirect) m_pc = npc;
        else if (!StallF && fetch_ok) m_pc = m_pc + 32'd4;
        m_boot = 0;

        @(posedge clk);
        #1;
        check("InstrD", InstrD, m_instr);
        check("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
        if (m_p8_ok) check("PCPlus8D", PCPlus8D, m_p8);
        check("FetchCnt", {27'b0, FetchCnt}, m_fcnt);
        check("MissCnt",  {27'b0, MissCnt},  m_mcnt);
    endtask

    initial begin
        logic [31:0] h_instr, h_p8, h_pc;

        // ---------------- reset state ----------------
        idle();
        reset = 1;
        model_reset(32'h0);
        #12;
        check_reset_values();
        reset = 0;

        // ---------------- streaming fetch ----------------
        step();                                   // BOOT bubble
        check("boot_bubble", {31'b0, ValidD}, 32'h0);
        repeat (3) step();                        // instr @0, @4, @8
        check("third_pcplus8", PCPlus8D, 32'h10);
        check("third_instr", InstrD, mem_word(32'h8));
        check("third_fetchcnt", {27'b0, FetchCnt}, 32'd3);
        step();                                   // instr @C, PC -> 0x10

        // ---------------- memory wait at 0x10 ----------------
        imem_valid = 0;
        repeat (3) step();
        check("wait_pc_hold", imem_addr, 32'h10);
        check("wait_misscnt", {27'b0, MissCnt}, 32'd3);
        imem_valid = 1;
        step();
        check("after_wait_instr", InstrD, mem_word(32'h10));
        check("after_wait_pcplus8", PCPlus8D, 32'h18);

        // ---------------- branch during WAIT and StallF ----------------
        imem_valid = 0;
        step();                                   // enter WAIT
        StallF = 1; BranchTakenE = 1; BranchTargetE = 32'h100;
        step();
        check("branch_pc", imem_addr, 32'h100);
        check("branch_bubble", {31'b0, ValidD}, 32'h0);
        idle();
        step();
        check("branch_first_instr", InstrD, mem_word(32'h100));

        // ---------------- branch beats writeback ----------------
        BranchTakenE = 1; BranchTargetE = 32'h200; PCSrcW = 1; ResultW = 32'h300;
        step();
        check("branch_priority", imem_addr, 32'h200);
        idle();
        step();
        PCSrcW = 1; ResultW = 32'h300;
        step();
        check("pcsrcw_redirect", imem_addr, 32'h300);
        idle();
        step();

        // ---------------- flush beats stall, then stall holds ----------------
        StallD = 1; FlushD = 1;
        step();
        check("flush_over_stall_instr", InstrD, NOP);
        check("flush_over_stall_valid", {31'b0, ValidD}, 32'h0);
        idle();
        step();
        h_instr = m_instr; h_p8 = m_p8; h_pc = m_pc;
        StallD = 1; StallF = 1;
        repeat (2) step();
        check("stalld_instr_hold", InstrD, h_instr);
        check("stalld_pcplus8_hold", PCPlus8D, h_p8);
        check("stallf_pc_hold", imem_addr, h_pc);
        idle();

        // ---------------- PC wrap-around ----------------
        BranchTakenE = 1; BranchTargetE = 32'hFFFF_FFFC;
        step();
        idle();
        step();
        check("wrap_pc", imem_addr, 32'h0);
        check("wrap_pcplus8", PCPlus8D, 32'h4);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            StallF        = ($urandom % 6) == 0;
            StallD        = ($urandom % 8) == 0;
            FlushD        = ($urandom % 10) == 0;
            BranchTakenE  = ($urandom % 12) == 0;
            BranchTargetE = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            PCSrcW        = ($urandom % 15) == 0;
            ResultW       = $urandom & 32'hFFFF_FFFC;
            imem_valid    = ($urandom % 4) != 0;
            step();
        end
        check("fetchcnt_saturated", {27'b0, FetchCnt}, CNT_MAX);
        check("misscnt_saturated",  {27'b0, MissCnt},  CNT_MAX);

        // ---------------- async reset mid-WAIT ----------------
        idle();
        BranchTakenE = 1; BranchTargetE = 32'h40;
        step();
        idle();
        imem_valid = 0;
        repeat (2) step();
        check("pre_reset_pc", imem_addr, 32'h40);
        #3;
        reset = 1;
        model_reset(32'h0);
        #1;
        check_reset_values();
        #3;
        reset = 0;
        idle();
        step();                                   // BOOT
        check("rst2_first_addr", imem_addr2, RST2);
        check("rst2_req", {31'b0, imem_req2}, 32'h1);
        step();
        check("rst2_first_instr", InstrD2, mem_word(RST2));
        check("rst2_first_pcplus8", PCPlus8D2, RST2 + 32'd8);
        check("rst2_first_valid", {31'b0, ValidD2}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
